// File: rtl/sw_debounce_pkg.sv
// Shared constants for the switch debouncer: switch count and the layout
// of the mux data/select fields within the raw switch vector.
package sw_debounce_pkg;

  localparam int unsigned NUM_SW  = 10;
  localparam int unsigned FIELD_W = 2;

  localparam int unsigned X0_OFS = 0;
  localparam int unsigned X1_OFS = 2;
  localparam int unsigned X2_OFS = 4;
  localparam int unsigned X3_OFS = 6;
  localparam int unsigned Y_OFS  = 8;

  // Extract one FIELD_W-wide field from the debounced switch vector.
  function automatic logic [FIELD_W-1:0] field_of(input logic [NUM_SW-1:0] vec,
                                                  input int unsigned ofs);
    field_of = vec[ofs +: FIELD_W];
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer: two-flop synchronizer, qualification counter and
// stable-value register, with a flag marking the edge on which it changes.
module debounce_bit #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic hold,
  output logic level,
  output logic chg_c
);

  localparam int unsigned      CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;

  // Synchronizer keeps sampling even while hold freezes the qualifier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Any cycle where the synchronized bit matches the stable value restarts
  // qualification, so a glitch shorter than DEB_CYCLES never gets through.
  always_comb begin
    cnt_nxt   = cnt;
    level_nxt = level;
    chg_c     = 1'b0;
    if (!hold) begin
      if (sync2 == level) begin
        cnt_nxt = '0;
      end else if (cnt == CNT_LAST) begin
        level_nxt = sync2;
        cnt_nxt   = '0;
        chg_c     = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      level <= level_nxt;
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Debounces ten raw switches into four 2-bit mux data fields and a 2-bit
// select, pulsing upd for one cycle whenever any debounced bit changes.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SW-1:0]  sw,
  input  logic               hold,
  output logic [FIELD_W-1:0] X0,
  output logic [FIELD_W-1:0] X1,
  output logic [FIELD_W-1:0] X2,
  output logic [FIELD_W-1:0] X3,
  output logic [FIELD_W-1:0] Y,
  output logic               upd
);

  logic [NUM_SW-1:0] level;
  logic [NUM_SW-1:0] chg_c;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
    debounce_bit #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sw[i]),
      .hold (hold),
      .level(level[i]),
      .chg_c(chg_c[i])
    );
  end

  // Fields are straight slices of the stable registers.
  assign X0 = field_of(level, X0_OFS);
  assign X1 = field_of(level, X1_OFS);
  assign X2 = field_of(level, X2_OFS);
  assign X3 = field_of(level, X3_OFS);
  assign Y  = field_of(level, Y_OFS);

  // One pulse per qualifying edge, however many bits changed on it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd <= 1'b0;
    end else begin
      upd <= |chg_c;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with DEB_CYCLES=4: table of settled patterns plus
// hand-written glitch, hold and mid-qualification reset sequences.
module tb_sw_debounce;

  localparam int unsigned DEB = 4;
  // Drive just after edge c -> first sample at c+1 -> output at c+1+DEB+1.
  localparam int LAT = DEB + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hold;
  logic [9:0] sw;
  logic [1:0] x0, x1, x2, x3, y;
  logic       upd;
  logic [9:0] outs;

  assign outs = {y, x3, x2, x1, x0};

  sw_debounce #(.DEB_CYCLES(DEB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw),
    .hold (hold),
    .X0   (x0),
    .X1   (x1),
    .X2   (x2),
    .X3   (x3),
    .Y    (y),
    .upd  (upd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [9:0] o;
    logic       u;
    string      name;
  } exp_t;

  typedef struct {
    logic [9:0] sw;
    logic [9:0] exp_out;
    logic       exp_upd;
    string      name;
  } vec_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [9:0] eo, input logic eu);
    n_chk++;
    if (outs !== eo || upd !== eu) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got out=%h upd=%b, want out=%h upd=%b",
               name, cyc, outs, upd, eo, eu);
    end
  endtask

  task automatic push(input int from, input int to, input logic [9:0] o,
                      input logic u, input string name);
    for (int i = from; i <= to; i++) sbq.push_back('{i, o, u, name});
  endtask

  // Advance one edge, then compare every expectation due on that edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      e = sbq.pop_front();
      if (e.at < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s: expectation for cyc=%0d never compared (now %0d)",
                 e.name, e.at, cyc);
      end else begin
        check(e.name, e.o, e.u);
      end
    end
  endtask

  vec_t       vecs[9];
  logic [9:0] cur;
  int         c;

  initial begin
    vecs[0] = '{10'h000, 10'h000, 1'b1, "all_clear"};
    vecs[1] = '{10'h003, 10'h003, 1'b1, "x0_11"};
    vecs[2] = '{10'h0F3, 10'h0F3, 1'b1, "x2x3_11"};
    vecs[3] = '{10'h2AA, 10'h2AA, 1'b1, "alt_a"};
    vecs[4] = '{10'h2AA, 10'h2AA, 1'b0, "no_change"};
    vecs[5] = '{10'h155, 10'h155, 1'b1, "alt_5"};
    vecs[6] = '{10'h000, 10'h000, 1'b1, "clear2"};
    vecs[7] = '{10'h101, 10'h101, 1'b1, "x0_y_same_edge"};
    vecs[8] = '{10'h000, 10'h000, 1'b1, "clear3"};

    // Reset with all switches high, then release.
    rst_n = 1'b0;
    hold  = 1'b0;
    sw    = 10'h3FF;
    repeat (2) tick();
    check("reset_state", 10'h000, 1'b0);
    rst_n = 1'b1;
    c = cyc;
    push(c + 1, c + LAT - 1, 10'h000, 1'b0, "post_reset_wait");
    push(c + LAT, c + LAT, 10'h3FF, 1'b1, "post_reset_rise");
    push(c + LAT + 1, c + LAT + 2, 10'h3FF, 1'b0, "post_reset_settle");
    repeat (LAT + 2) tick();
    cur = 10'h3FF;

    for (int k = 0; k < 9; k++) begin
      c  = cyc;
      sw = vecs[k].sw;
      push(c + 1, c + LAT - 1, cur, 1'b0, {vecs[k].name, "_wait"});
      push(c + LAT, c + LAT, vecs[k].exp_out, vecs[k].exp_upd, {vecs[k].name, "_edge"});
      push(c + LAT + 1, c + LAT + 2, vecs[k].exp_out, 1'b0, {vecs[k].name, "_settle"});
      repeat (LAT + 2) tick();
      cur = vecs[k].exp_out;
    end

    // Three-cycle pulse on sw[9] must never qualify.
    c = cyc;
    push(c + 1, c + 12, 10'h000, 1'b0, "glitch_y");
    sw = 10'h200;
    repeat (3) tick();
    sw = 10'h000;
    repeat (9) tick();

    // Hold over edges E0+2..E0+6 delays X2[0] to E0+10.
    c = cyc;
    sw = 10'h010;
    push(c + 1, c + 10, 10'h000, 1'b0, "hold_wait");
    push(c + 11, c + 11, 10'h010, 1'b1, "hold_edge");
    push(c + 12, c + 13, 10'h010, 1'b0, "hold_settle");
    repeat (2) tick();
    hold = 1'b1;
    repeat (5) tick();
    hold = 1'b0;
    repeat (6) tick();

    // Reset at E0+3 discards sw[6] progress and clears X2; both requalify.
    c = cyc;
    sw = 10'h050;
    push(c + 1, c + 3, 10'h010, 1'b0, "rst_mid_pre");
    push(c + 4, c + 9, 10'h000, 1'b0, "rst_mid_wait");
    push(c + 10, c + 10, 10'h050, 1'b1, "rst_mid_edge");
    push(c + 11, c + 12, 10'h050, 1'b0, "rst_mid_settle");
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (8) tick();

    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at cyc=%0d, want test completion", cyc);
    $fatal(1);
  end

endmodule
